time_set_unit: RTL
==================

Name: time_set_unit

Overview:
- Front-panel entry stage directly upstream of the clock/alarm top level.
- Debounces the user push-buttons and lets the user edit an hour/minute value in BCD.
- Drives the BCD time-input buses (hr_i_t, hr_i_o, min_i_t, min_i_o) continuously.
- Issues a stretched load strobe to exactly one target: time_ow or one of the three alarm enables, so the 1 Hz domain can sample it.

Parameters:
- DEBOUNCE_CYCLES, 20, consecutive equal samples required before a button level is accepted.
- STROBE_CYCLES, 3000, clk cycles a load strobe is held high; must exceed one 1 Hz period.

Ports:
- clk  in  1  fast system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_mode  in  1  raw button; cycles the edit state.
- btn_inc  in  1  raw button; increments the field being edited.
- btn_target  in  1  raw button; cycles the load target.
- btn_load  in  1  raw button; commits the value to the target.
- hr_i_t  out  4  hours tens, BCD.
- hr_i_o  out  4  hours ones, BCD.
- min_i_t  out  4  minutes tens, BCD.
- min_i_o  out  4  minutes ones, BCD.
- time_ow  out  1  time overwrite strobe.
- alarmOne  out  1  alarm 1 arm strobe.
- alarmTwo  out  1  alarm 2 arm strobe.
- alarmThree  out  1  alarm 3 arm strobe.
- target  out  2  current load target: 0 = TIME, 1 = A1, 2 = A2, 3 = A3.
- edit_state  out  2  current state: 0 = IDLE, 1 = EDIT_HR, 2 = EDIT_MIN, 3 = STROBE.

Behaviour:
- Reset (reset = 0, asynchronous):
  - All BCD outputs = 0, so the entry is 00:00.
  - target = 0, edit_state = IDLE.
  - All strobes = 0; debounce counters and synchronisers cleared.
- Input conditioning, per button:
  - 2-flop synchroniser feeds the debounce counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive samples differ from it.
  - A press event is a one-cycle pulse on an accepted 0->1 transition.
  - Latency from a clean raw edge to the press pulse = DEBOUNCE_CYCLES + 2 cycles.
- Simultaneous press events in one cycle: only the highest-priority event acts (load > mode > target > inc); the others are dropped.
- State machine:
  - IDLE:
    - mode -> EDIT_HR.
    - target -> target+1 mod 4.
    - inc and load are ignored.
  - EDIT_HR:
    - inc -> hours +1, wrapping 23 -> 00.
    - mode -> EDIT_MIN.
    - target -> cycles the target.
    - load -> STROBE.
  - EDIT_MIN:
    - inc -> minutes +1, wrapping 59 -> 00.
    - mode -> IDLE.
    - target -> cycles the target.
    - load -> STROBE.
  - STROBE:
    - The selected strobe is high for exactly STROBE_CYCLES cycles, starting the cycle after the load press.
    - All button events are ignored and the BCD outputs are frozen.
    - On expiry the strobe drops the same cycle; next state is IDLE and target is unchanged.
- BCD arithmetic:
  - Hours: ones 9 -> 0 with tens+1; 23 -> 00.
  - Minutes: ones 9 -> 0 with tens+1; 59 -> 00.
  - The tens digit never exceeds 2 for hours or 5 for minutes; the outputs are never non-BCD.
- Strobe rules:
  - At most one strobe is high at any time.
  - Strobes are registered outputs (no glitches).
- Reset asserted mid-strobe: the strobe drops immediately (asynchronously) and the block returns to the reset state.

Test Plan:
- Reset -> outputs 00:00, edit_state = 0, target = 0, all strobes 0; then a 10-cycle raw pulse shorter than DEBOUNCE_CYCLES on btn_mode -> no state change.
- mode, then 24 inc presses -> hours step 00..23 then 00 (hr_i_t / hr_i_o = 0/0); minutes unchanged.
- mode x2, then 60 inc presses -> minutes 00..59 then 00; check the 09->10 and 59->00 digit carries.
- From 00:00: mode, 7 inc, mode, 45 inc, then target x2, then load -> outputs 07:45, alarmTwo high for exactly STROBE_CYCLES cycles, time_ow/alarmOne/alarmThree stay 0, then edit_state = 0.
- load and inc press events in the same cycle while in EDIT_HR -> STROBE entered, hours not incremented.
- reset pulled low midway through the time_ow strobe -> time_ow = 0 immediately, outputs 00:00, target = 0.

Source files
------------

// File: rtl/time_set_unit.sv
// Front-panel time entry: debounces four buttons, edits an HH:MM value in BCD
// and issues a stretched load strobe to the selected time/alarm target.
module time_set_unit #(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned STROBE_CYCLES   = 3000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_target,
    input  logic       btn_load,
    output logic [3:0] hr_i_t,
    output logic [3:0] hr_i_o,
    output logic [3:0] min_i_t,
    output logic [3:0] min_i_o,
    output logic       time_ow,
    output logic       alarmOne,
    output logic       alarmTwo,
    output logic       alarmThree,
    output logic [1:0] target,
    output logic [1:0] edit_state
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned SW = $clog2(STROBE_CYCLES + 1);
    localparam int unsigned NB = 4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EDIT_HR  = 2'd1,
        S_EDIT_MIN = 2'd2,
        S_STROBE   = 2'd3
    } state_t;

    // Button bit order: 0 = mode, 1 = inc, 2 = target, 3 = load.
    logic [NB-1:0] raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [DW-1:0] db_cnt [NB];

    assign raw = {btn_load, btn_target, btn_inc, btn_mode};

    // Synchronise and debounce; a press pulses for one cycle on an accepted rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < int'(NB); i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < int'(NB); i++) begin
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        level[i]  <= sync2[i];
                        press[i]  <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Only the highest-priority event of a cycle acts: load > mode > target > inc.
    logic ev_load, ev_mode, ev_tgt, ev_inc;
    assign ev_load = press[3];
    assign ev_mode = press[0] & ~press[3];
    assign ev_tgt  = press[2] & ~press[3] & ~press[0];
    assign ev_inc  = press[1] & ~press[3] & ~press[0] & ~press[2];

    function automatic logic [7:0] hr_next(input logic [3:0] t, input logic [3:0] o);
        if (t == 4'd2 && o == 4'd3) return 8'h00;
        if (o == 4'd9)              return {t + 4'd1, 4'd0};
        return {t, o + 4'd1};
    endfunction

    function automatic logic [7:0] min_next(input logic [3:0] t, input logic [3:0] o);
        if (t == 4'd5 && o == 4'd9) return 8'h00;
        if (o == 4'd9)              return {t + 4'd1, 4'd0};
        return {t, o + 4'd1};
    endfunction

    state_t        state;
    logic [1:0]    tgt;
    logic [3:0]    strobe_q;
    logic [SW-1:0] s_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            tgt      <= 2'd0;
            hr_i_t   <= 4'd0;
            hr_i_o   <= 4'd0;
            min_i_t  <= 4'd0;
            min_i_o  <= 4'd0;
            strobe_q <= 4'd0;
            s_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ev_mode)     state <= S_EDIT_HR;
                    else if (ev_tgt) tgt   <= tgt + 2'd1;
                end
                S_EDIT_HR: begin
                    if (ev_load) begin
                        state    <= S_STROBE;
                        strobe_q <= 4'b0001 << tgt;
                        s_cnt    <= '0;
                    end else if (ev_mode) begin
                        state <= S_EDIT_MIN;
                    end else if (ev_tgt) begin
                        tgt <= tgt + 2'd1;
                    end else if (ev_inc) begin
                        {hr_i_t, hr_i_o} <= hr_next(hr_i_t, hr_i_o);
                    end
                end
                S_EDIT_MIN: begin
                    if (ev_load) begin
                        state    <= S_STROBE;
                        strobe_q <= 4'b0001 << tgt;
                        s_cnt    <= '0;
                    end else if (ev_mode) begin
                        state <= S_IDLE;
                    end else if (ev_tgt) begin
                        tgt <= tgt + 2'd1;
                    end else if (ev_inc) begin
                        {min_i_t, min_i_o} <= min_next(min_i_t, min_i_o);
                    end
                end
                S_STROBE: begin
                    // Strobe stays up long enough for the 1 Hz domain to see it.
                    if (s_cnt == SW'(STROBE_CYCLES - 1)) begin
                        strobe_q <= 4'd0;
                        state    <= S_IDLE;
                    end else begin
                        s_cnt <= s_cnt + SW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign time_ow    = strobe_q[0];
    assign alarmOne   = strobe_q[1];
    assign alarmTwo   = strobe_q[2];
    assign alarmThree = strobe_q[3];
    assign target     = tgt;
    assign edit_state = state;

endmodule
